// File: rtl/mm_ctrl_pkg.sv
// Shared types and defaults for the matrix-multiply controller family.
// Holds the done-tracker state encoding and the delay/lane defaults.
package mm_ctrl_pkg;

    // Default delay-line depth and lane count shared with the controller.
    localparam int MM_MAX_LAT = 16;
    localparam int MM_CH      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } trk_state_t;

endpackage

// File: rtl/mm_valid_delay.sv
// Enabled multi-lane valid shift register with runtime tap select.
// Ports: clk, reset (async active-low), en (shift), clr (sync clear),
//        din (line input), tap (output index), dout (selected stage).
module mm_valid_delay #(
    parameter int MAX_LAT = 16,
    parameter int CH      = 4,
    parameter int TW      = $clog2(MAX_LAT)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          clr,
    input  logic [CH-1:0] din,
    input  logic [TW-1:0] tap,
    output logic [CH-1:0] dout
);

    logic [CH-1:0] line [MAX_LAT];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MAX_LAT; i++) begin
                line[i] <= '0;
            end
        end else if (clr) begin
            for (int i = 0; i < MAX_LAT; i++) begin
                line[i] <= '0;
            end
        end else if (en) begin
            line[0] <= din;
            for (int i = 1; i < MAX_LAT; i++) begin
                line[i] <= line[i-1];
            end
        end
    end

    // Stage 0 already holds one cycle of delay, so tap N gives N+1.
    assign dout = line[tap];

endmodule

// File: rtl/mm_done_tracker.sv
// Tile completion tracker: delays lane valids by a programmed latency
// and counts output beats against a target, pulsing done at the end.
// Ports: clk, reset (async active-low), start, abort, en, lat, target,
//        in_valid -> out_valid, count, busy, done.
module mm_done_tracker
    import mm_ctrl_pkg::*;
#(
    parameter int MAX_LAT = MM_MAX_LAT,
    parameter int CH      = MM_CH,
    parameter int CNT_W   = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       en,
    input  logic [$clog2(MAX_LAT)-1:0] lat,
    input  logic [CNT_W-1:0]           target,
    input  logic [CH-1:0]              in_valid,
    output logic [CH-1:0]              out_valid,
    output logic [CNT_W-1:0]           count,
    output logic                       busy,
    output logic                       done
);

    localparam int TW = $clog2(MAX_LAT);

    trk_state_t     state;
    logic [TW-1:0]  lat_q;
    logic [CNT_W-1:0] target_q;
    logic [CH-1:0]  line_in;
    logic [CNT_W-1:0] cnt_nxt;
    logic           beat;

    // Only valids launched during a run enter the line; leftovers drain.
    assign line_in = (state == RUN) ? in_valid : '0;

    mm_valid_delay #(
        .MAX_LAT(MAX_LAT),
        .CH     (CH),
        .TW     (TW)
    ) u_delay (
        .clk  (clk),
        .reset(reset),
        .en   (en),
        .clr  (abort),
        .din  (line_in),
        .tap  (lat_q),
        .dout (out_valid)
    );

    // Any active lane makes one beat; the count never passes target.
    assign beat    = (state == RUN) && en && (|out_valid)
                     && (count != target_q);
    assign cnt_nxt = count + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            lat_q    <= '0;
            target_q <= '0;
            count    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        lat_q    <= lat;
                        target_q <= target;
                        count    <= '0;
                        if (target == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (beat) begin
                        count <= cnt_nxt;
                        if (cnt_nxt == target_q) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // Leaves regardless of en: the pulse is one cycle.
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mm_done_tracker.sv
// Self-checking bench for mm_done_tracker: directed scenarios plus
// randomized runs compared against a queue-based reference model.
module tb_mm_done_tracker;

    localparam int MAX_LAT = 16;
    localparam int CH      = 4;
    localparam int CNT_W   = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             abort;
    logic             en;
    logic [3:0]       lat;
    logic [CNT_W-1:0] target;
    logic [CH-1:0]    in_valid;
    logic [CH-1:0]    out_valid;
    logic [CNT_W-1:0] count;
    logic             busy;
    logic             done;

    int checks = 0;
    int errors = 0;
    int done_seen = 0;
    string phase = "reset";

    // Reference model: mode 0 idle, 1 running, 2 finishing.
    int m_mode;
    int m_lat;
    int m_tgt;
    int m_cnt;
    logic [CH-1:0] hist [$];

    mm_done_tracker #(
        .MAX_LAT(MAX_LAT),
        .CH     (CH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
        .en       (en),
        .lat      (lat),
        .target   (target),
        .in_valid (in_valid),
        .out_valid(out_valid),
        .count    (count),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    function automatic logic [CH-1:0] model_tap();
        if (hist.size() > m_lat) return hist[hist.size() - 1 - m_lat];
        return '0;
    endfunction

    task automatic model_reset();
        hist.delete();
        m_mode = 0;
        m_lat  = 0;
        m_tgt  = 0;
        m_cnt  = 0;
    endtask

    task automatic model_edge();
        logic [CH-1:0] cur;
        cur = model_tap();
        if (abort) begin
            hist.delete();
            m_mode = 0;
        end else begin
            if (en) begin
                hist.push_back(m_mode == 1 ? in_valid : 4'h0);
                if (hist.size() > MAX_LAT) void'(hist.pop_front());
            end
            case (m_mode)
                0: if (start) begin
                    m_lat  = int'(lat);
                    m_tgt  = int'(target);
                    m_cnt  = 0;
                    m_mode = (target == 0) ? 2 : 1;
                end
                1: if (en && cur != 0 && m_cnt < m_tgt) begin
                    m_cnt++;
                    if (m_cnt == m_tgt) m_mode = 2;
                end
                default: m_mode = 0;
            endcase
        end
    endtask

    task automatic check_all();
        logic [CH-1:0]    e_ov;
        logic [CNT_W-1:0] e_cnt;
        logic             e_busy;
        logic             e_done;
        e_ov   = model_tap();
        e_cnt  = m_cnt[CNT_W-1:0];
        e_busy = (m_mode == 1);
        e_done = (m_mode == 2);
        checks++;
        assert (out_valid === e_ov) else begin
            errors++;
            $error("FAIL %s out_valid: got %h expected %h",
                   phase, out_valid, e_ov);
        end
        checks++;
        assert (count === e_cnt) else begin
            errors++;
            $error("FAIL %s count: got %0d expected %0d",
                   phase, count, e_cnt);
        end
        checks++;
        assert (busy === e_busy) else begin
            errors++;
            $error("FAIL %s busy: got %b expected %b",
                   phase, busy, e_busy);
        end
        checks++;
        assert (done === e_done) else begin
            errors++;
            $error("FAIL %s done: got %b expected %b",
                   phase, done, e_done);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        if (!reset) model_reset();
        else model_edge();
        #1;
        if (done === 1'b1) done_seen++;
        check_all();
    endtask

    task automatic quiet();
        start    = 1'b0;
        abort    = 1'b0;
        en       = 1'b1;
        in_valid = '0;
    endtask

    task automatic expect_dones(int n);
        checks++;
        assert (done_seen == n) else begin
            errors++;
            $error("FAIL %s done_pulses: got %0d expected %0d",
                   phase, done_seen, n);
        end
        done_seen = 0;
    endtask

    task automatic kick(int l, int t);
        lat    = l[3:0];
        target = t[CNT_W-1:0];
        start  = 1'b1;
        cyc();
        start  = 1'b0;
    endtask

    initial begin
        reset  = 1'b0;
        lat    = '0;
        target = '0;
        quiet();
        model_reset();
        #1;
        check_all();
        cyc();
        cyc();
        reset = 1'b1;
        cyc();
        done_seen = 0;

        phase = "basic";
        kick(2, 4);
        in_valid = 4'b0001;
        repeat (4) cyc();
        in_valid = '0;
        repeat (6) cyc();
        expect_dones(1);

        phase = "stall";
        kick(2, 4);
        in_valid = 4'b0001;
        repeat (2) cyc();
        en = 1'b0;
        repeat (2) cyc();
        en = 1'b1;
        repeat (2) cyc();
        in_valid = '0;
        repeat (8) cyc();
        expect_dones(1);

        phase = "overflow";
        kick(1, 3);
        in_valid = 4'b1111;
        repeat (5) cyc();
        in_valid = '0;
        repeat (6) cyc();
        expect_dones(1);

        phase = "target0";
        kick(0, 0);
        repeat (3) cyc();
        expect_dones(1);

        phase = "maxlat";
        kick(MAX_LAT - 1, 1);
        in_valid = 4'b0101;
        cyc();
        in_valid = '0;
        repeat (18) cyc();
        expect_dones(1);

        phase = "start_in_run";
        kick(3, 2);
        in_valid = 4'b0010;
        cyc();
        lat    = 4'd0;
        target = 8'd9;
        start  = 1'b1;
        cyc();
        start    = 1'b0;
        in_valid = '0;
        repeat (8) cyc();
        expect_dones(1);

        phase = "abort";
        kick(4, 5);
        in_valid = 4'b0001;
        repeat (2) cyc();
        in_valid = '0;
        cyc();
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        repeat (6) cyc();
        expect_dones(0);

        phase = "reset_mid";
        kick(3, 4);
        in_valid = 4'b1000;
        repeat (3) cyc();
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_all();
        quiet();
        cyc();
        reset = 1'b1;
        cyc();
        done_seen = 0;

        phase = "start_abort";
        lat    = 4'd0;
        target = 8'd1;
        start  = 1'b1;
        abort  = 1'b1;
        cyc();
        quiet();
        in_valid = 4'b0001;
        repeat (3) cyc();
        in_valid = '0;
        cyc();
        expect_dones(0);

        phase = "random";
        for (int r = 0; r < 12; r++) begin
            quiet();
            kick($urandom_range(0, MAX_LAT - 1), $urandom_range(0, 6));
            for (int c = 0; c < 40; c++) begin
                en       = ($urandom_range(0, 3) != 0);
                in_valid = ($urandom_range(0, 1) != 0) ?
                           4'($urandom_range(0, 15)) : 4'h0;
                abort    = ($urandom_range(0, 59) == 0);
                start    = ($urandom_range(0, 19) == 0);
                lat      = 4'($urandom_range(0, MAX_LAT - 1));
                target   = 8'($urandom_range(0, 6));
                cyc();
            end
        end
        quiet();
        repeat (20) cyc();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
